// File: rtl/dbus_sram_responder_pkg.sv
// Shared data-bus types for the pipeline's dbus port.
// Request/response bundles exchanged between initiators and responders.
package dbus_sram_responder_pkg;

  typedef enum logic [1:0] {
    MSIZE1,
    MSIZE2,
    MSIZE4,
    MSIZE8
  } msize_t;

  typedef logic [7:0] strobe_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    strobe_t     strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

endpackage

// File: rtl/dbus_sram_responder_array.sv
// 64-bit word array: combinational read, byte-strobed synchronous write.
// Isolated so FPGA builds can substitute a BRAM wrapper.
module sram_word_array
  import dbus_sram_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = 12
) (
  input  logic          clk,
  input  logic [AW-1:0] raddr,
  output logic [63:0]   rdata,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  strobe_t       wstrb,
  input  logic [63:0]   wdata
);

  logic [63:0] mem [DEPTH_WORDS];

  assign rdata = mem[raddr];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 8; i++) begin
        if (wstrb[i]) begin
          mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dbus_sram_responder.sv
// Fixed-latency dbus responder backed by a word SRAM array.
// Handles flush abandon, range errors and a sticky protocol flag.
module dbus_sram_responder
  import dbus_sram_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 2,
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       range_err,
  output logic       proto_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic [63:0] addr;
    msize_t      size;
    strobe_t     strobe;
    logic [63:0] data;
  } req_reg_t;

  state_t      state, state_n;
  req_reg_t    req_q;
  logic [3:0]  cnt, cnt_n;
  logic        load;
  logic [63:0] off;
  logic        in_range;
  logic        mismatch;
  logic        proto_set;
  logic        we;
  logic [63:0] rdata;

  assign off      = req_q.addr - BASE_ADDR;
  assign in_range = (req_q.addr >= BASE_ADDR)
                 && (off[63:AW+3] == '0);

  assign mismatch = (dreq.addr != req_q.addr)
                 || (dreq.strobe != req_q.strobe)
                 || (dreq.size != req_q.size);

  assign proto_set = (state != IDLE) && dreq.valid
                  && mismatch;

  // Initiator dropping valid in RESP suppresses the store only.
  assign we = (state == RESP) && dreq.valid
           && in_range && (|req_q.strobe);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        if (dreq.valid) begin
          load    = 1'b1;
          cnt_n   = 4'(LATENCY - 1);
          state_n = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (!dreq.valid) begin
          state_n = IDLE;
        end else if (cnt == 4'd1) begin
          state_n = RESP;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    dresp     = '0;
    range_err = 1'b0;
    if (state == RESP) begin
      dresp.addr_ok = 1'b1;
      dresp.data_ok = 1'b1;
      dresp.data    = in_range ? rdata : '0;
      range_err     = !in_range;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      req_q     <= '0;
      proto_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (load) begin
        req_q <= '{addr:   dreq.addr,
                   size:   dreq.size,
                   strobe: dreq.strobe,
                   data:   dreq.data};
      end
      if (proto_set) begin
        proto_err <= 1'b1;
      end
    end
  end

  sram_word_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk  (clk),
    .raddr(off[AW+2:3]),
    .rdata(rdata),
    .we   (we),
    .waddr(off[AW+2:3]),
    .wstrb(req_q.strobe),
    .wdata(req_q.data)
  );

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Scoreboard bench: two responders (latency 2 and 1) vs a memory model.
// Driver pushes expected responses; negedge monitor pops and compares.
module tb_dbus_sram_responder;
  import dbus_sram_responder_pkg::*;

  localparam int          DEPTH = 64;
  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam logic [63:0] TOP   = BASE + 64'(8 * DEPTH);

  typedef struct {
    logic [63:0] data;
    bit          chk;
    logic        rerr;
    longint      cyc;
  } exp_t;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  dbus_req_t  dreq  [2];
  dbus_resp_t dresp [2];
  logic       range_err [2];
  logic       proto_err [2];

  exp_t        sbq0 [$];
  exp_t        sbq1 [$];
  logic [63:0] mem   [2][DEPTH];
  bit          known [2][DEPTH];
  int          n_cmp = 0;
  int          n_bad = 0;
  longint      cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dbus_sram_responder #(
    .DEPTH_WORDS(DEPTH), .LATENCY(2), .BASE_ADDR(BASE)
  ) u0 (
    .clk(clk), .reset(reset), .dreq(dreq[0]), .dresp(dresp[0]),
    .range_err(range_err[0]), .proto_err(proto_err[0])
  );

  dbus_sram_responder #(
    .DEPTH_WORDS(DEPTH), .LATENCY(1), .BASE_ADDR(BASE)
  ) u1 (
    .clk(clk), .reset(reset), .dreq(dreq[1]), .dresp(dresp[1]),
    .range_err(range_err[1]), .proto_err(proto_err[1])
  );

  task automatic check(input string name, input logic [65:0] act,
                       input logic [65:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (cycle %0d)",
               name, act, req, cyc);
    end
  endtask

  // Reference: word index = (addr - BASE) / 8, byte-lane merge on store.
  function automatic exp_t model(input int u, input logic [63:0] a,
                                 input logic [7:0] s,
                                 input logic [63:0] d, input bit wr);
    exp_t e;
    int   idx;
    e.cyc = 0;
    if (a < BASE || a >= TOP) begin
      e.data = '0; e.chk = 1'b1; e.rerr = 1'b1;
      return e;
    end
    idx    = int'((a - BASE) / 8);
    e.data = mem[u][idx];
    e.chk  = known[u][idx];
    e.rerr = 1'b0;
    if (wr) begin
      for (int i = 0; i < 8; i++)
        if (s[i]) mem[u][idx][8*i +: 8] = d[8*i +: 8];
      if (s == 8'hFF) known[u][idx] = 1'b1;
    end
    return e;
  endfunction

  // drop: cycle after acceptance in which valid falls (0 = never).
  task automatic xact(input int u, input logic [63:0] a,
                      input logic [7:0] s, input logic [63:0] d,
                      input int drop, input bit perturb);
    int   lat;
    bit   abandon;
    exp_t e;
    lat     = (u == 0) ? 2 : 1;
    abandon = (drop > 0) && (drop < lat);
    dreq[u].valid  = 1'b1;
    dreq[u].addr   = a;
    dreq[u].size   = msize_t'($urandom_range(0, 3));
    dreq[u].strobe = s;
    dreq[u].data   = d;
    if (!abandon) begin
      e     = model(u, a, s, d, drop == 0);
      e.cyc = cyc + lat;
      if (u == 0) sbq0.push_back(e);
      else sbq1.push_back(e);
    end
    for (int c = 1; c <= lat; c++) begin
      @(posedge clk); #1;
      if (drop == c) dreq[u].valid = 1'b0;
      if (perturb && c == 1) dreq[u].addr = a + 64'd8;
    end
    @(posedge clk); #1;
    dreq[u].valid = 1'b0;
  endtask

  task automatic mon(input int u);
    exp_t e;
    bit   have;
    if (dresp[u].data_ok) begin
      have = 1'b0;
      if (u == 0 && sbq0.size() > 0) begin
        e = sbq0.pop_front(); have = 1'b1;
      end
      if (u == 1 && sbq1.size() > 0) begin
        e = sbq1.pop_front(); have = 1'b1;
      end
      check($sformatf("u%0d expected_pending", u), 66'(have), 66'd1);
      if (have) begin
        if (e.chk)
          check($sformatf("u%0d data", u), 66'(dresp[u].data), 66'(e.data));
        check($sformatf("u%0d range_err", u), 66'(range_err[u]), 66'(e.rerr));
        check($sformatf("u%0d addr_ok", u), 66'(dresp[u].addr_ok), 66'd1);
        check($sformatf("u%0d resp_cycle", u), 66'(cyc), 66'(e.cyc));
      end
    end else begin
      check($sformatf("u%0d idle_outputs", u),
            {dresp[u].addr_ok, range_err[u], dresp[u].data}, 66'd0);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      mon(0);
      mon(1);
    end
  end

  initial begin
    int          r;
    int          lat;
    int          drop;
    logic [63:0] a;
    logic [7:0]  s;
    dreq[0] = '0;
    dreq[1] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check($sformatf("u%0d reset_dresp", u), 66'(dresp[u]), 66'd0);
      check($sformatf("u%0d reset_range_err", u), 66'(range_err[u]), 66'd0);
      check($sformatf("u%0d reset_proto_err", u), 66'(proto_err[u]), 66'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;

    for (int u = 0; u < 2; u++)
      for (int i = 0; i < DEPTH; i++)
        xact(u, BASE + 64'(8 * i), 8'hFF, {$urandom, $urandom}, 0, 0);

    xact(0, BASE, 8'hFF, 64'h1122_3344_5566_7788, 0, 0);
    xact(0, BASE, 8'h00, 64'h0, 0, 0);
    xact(0, BASE, 8'b0000_1100, 64'h0000_0000_AABB_0000, 0, 0);
    xact(0, BASE, 8'h00, 64'h0, 0, 0);
    xact(0, BASE + 64'd8, 8'hFF, 64'hDEAD, 1, 0);
    xact(0, BASE + 64'd8, 8'h00, 64'h0, 0, 0);
    xact(0, 64'h7FFF_FFF8, 8'h00, 64'h0, 0, 0);
    xact(0, TOP, 8'h00, 64'h0, 0, 0);
    xact(0, TOP, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    xact(0, BASE, 8'h00, 64'h0, 0, 0);
    xact(0, BASE + 64'd16, 8'hFF, 64'hCAFE, 2, 0);
    xact(0, BASE + 64'd16, 8'h00, 64'h0, 0, 0);

    check("u0 proto_err_before", 66'(proto_err[0]), 66'd0);
    xact(0, BASE + 64'h10, 8'h00, 64'h0, 0, 1);
    check("u0 proto_err_set", 66'(proto_err[0]), 66'd1);
    xact(0, BASE + 64'h18, 8'h00, 64'h0, 0, 0);
    check("u0 proto_err_sticky", 66'(proto_err[0]), 66'd1);

    dreq[0].valid  = 1'b1;
    dreq[0].addr   = BASE + 64'd32;
    dreq[0].size   = MSIZE8;
    dreq[0].strobe = 8'hFF;
    dreq[0].data   = 64'hBAD0_BAD0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    dreq[0].valid = 1'b0;
    @(negedge clk);
    check("u0 proto_err_after_reset", 66'(proto_err[0]), 66'd0);
    @(posedge clk); #1;
    xact(0, BASE + 64'd32, 8'h00, 64'h0, 0, 0);

    xact(1, BASE, 8'h00, 64'h0, 0, 0);
    xact(1, BASE + 64'd8, 8'h00, 64'h0, 0, 0);
    xact(1, BASE + 64'd16, 8'h00, 64'h0, 0, 0);

    for (int u = 0; u < 2; u++) begin
      lat = (u == 0) ? 2 : 1;
      for (int n = 0; n < 150; n++) begin
        r = $urandom_range(0, 9);
        if (r < 8)
          a = BASE + 64'(8 * $urandom_range(0, DEPTH - 1))
                   + 64'($urandom_range(0, 7));
        else if (r == 8)
          a = BASE - 64'(8 * $urandom_range(1, 4));
        else
          a = TOP + 64'(8 * $urandom_range(0, 3));
        s    = ($urandom_range(0, 9) < 4) ? 8'h00 : 8'($urandom);
        drop = ($urandom_range(0, 9) == 0) ? $urandom_range(1, lat) : 0;
        xact(u, a, s, {$urandom, $urandom}, drop, 0);
      end
    end

    repeat (5) @(posedge clk);
    #1;
    check("u0 drain", 66'(sbq0.size()), 66'd0);
    check("u1 drain", 66'(sbq1.size()), 66'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dbus_sram_responder.md
Name: dbus_sram_responder

Overview:
- Data-bus responder (slave end of the dbus_req_t / dbus_resp_t handshake) backed by a word-addressed SRAM array.
- Serves both data accesses from the memory stage and page-table-walk reads from the translate unit.
- Fixed, configurable response latency, byte-strobe writes, out-of-range detection, and abandonment of in-flight requests when the initiator drops valid (flush).
- Used as the simulation/FPGA data memory behind the pipeline's dbus port.

Parameters:
- DEPTH_WORDS, 4096: number of 64-bit words in the array; must be a power of 2.
- LATENCY, 2: cycles from request acceptance to data_ok; legal range 1..15.
- BASE_ADDR, 64'h8000_0000: physical byte address of word 0.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- dreq  in  dbus_req_t  request from initiator: valid, addr[63:0], size, strobe[7:0], data[63:0]
- dresp  out  dbus_resp_t  response: addr_ok, data_ok, data[63:0]
- range_err  out  1  one-cycle pulse coincident with data_ok when the access was out of range
- proto_err  out  1  sticky; set on a handshake violation, cleared only by reset

Behaviour:
- Reset values:
  - state = IDLE
  - dresp.addr_ok = 0, dresp.data_ok = 0, dresp.data = 0
  - range_err = 0, proto_err = 0
  - Array contents are not cleared.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If dreq.valid = 1: latch addr, size, strobe, data into a request register; load cnt = LATENCY-1.
  - If LATENCY = 1, go to RESP; otherwise go to WAIT.
  - The acceptance cycle produces no response.
- WAIT:
  - Decrement cnt each cycle; go to RESP when cnt reaches 1.
  - If dreq.valid = 0 in any WAIT cycle: abandon the request, return to IDLE, perform no write, produce no data_ok.
- RESP (exactly one cycle):
  - dresp.addr_ok = 1 and dresp.data_ok = 1.
  - dresp.data = full aligned 64-bit word at index (addr - BASE_ADDR) >> 3, read before any write in the same cycle.
  - If the latched strobe is nonzero, write byte i of the latched data where strobe[i] = 1 in that same cycle.
  - Next state is IDLE.
  - If dreq.valid = 0 in the RESP cycle, treat as abandon: data_ok is still driven, but the write is suppressed.
- Data alignment: the responder returns and writes whole words unshifted; the initiator performs lane shifting. addr[2:0] and size are latched but do not affect the array access.
- Out of range: addr < BASE_ADDR or addr >= BASE_ADDR + 8*DEPTH_WORDS:
  - RESP still completes (data_ok = 1).
  - dresp.data = 0, no write, range_err = 1 for that cycle.
- Back-to-back requests: a new request is accepted no earlier than the cycle after RESP. Minimum occupancy is LATENCY+1 cycles per access. The initiator must present each request once only.
- Protocol check: proto_err is set if, while in WAIT or RESP with dreq.valid = 1, dreq.addr, dreq.strobe or dreq.size differs from the latched value. The latched request is still the one served.
- Reset mid-operation: reset in WAIT or RESP returns to IDLE next cycle, with no write and no data_ok.
- Outputs are registered from state. dresp.data_ok and addr_ok are 0 in every state except RESP.

Decomposition:
- dbus_req_t, dbus_resp_t, msize_t and strobe_t stay in the shared common package; no new typedefs there.
- The local state enum and the request-register struct are internal to the module.
- One sub-module, sram_word_array:
  - DEPTH_WORDS x 64 bits, one combinational-read / synchronous byte-strobed write port.
  - Kept separate so FPGA builds can swap in a BRAM wrapper.

Test Plan:
- Read latency: LATENCY=2; write word 0 of the array via a prior store, then hold valid=1, addr=0x8000_0000, strobe=0 -> data_ok high exactly 2 cycles after acceptance for one cycle, addr_ok=1, data equals the stored word.
- Strobed store: word 0 = 0x1122334455667788; store addr=0x8000_0000, strobe=8'b00001100, data=0x0000_0000_AABB_0000 -> subsequent load returns 0x11223344AABB7788; the store's own data_ok returns the old value 0x1122334455667788.
- Flush abandon: issue store strobe=8'hFF, data=0xDEAD to addr 0x8000_0008; drop valid in the first WAIT cycle -> no data_ok; a later load of 0x8000_0008 returns the prior value.
- Out of range: load addr=0x7FFF_FFF8, then load addr=0x8000_0000+8*DEPTH_WORDS -> each gives data_ok=1, data=0, range_err=1; a store with strobe=8'hFF to 0x8000_0000+8*DEPTH_WORDS leaves word 0 of the array unchanged.
- Protocol and reset:
  - Change addr from 0x8000_0010 to 0x8000_0018 mid-WAIT -> proto_err=1 sticky; response data comes from 0x8000_0010.
  - Assert reset in WAIT -> state IDLE, proto_err=0, no data_ok.
- Back-to-back: LATENCY=1, three loads at 0x8000_0000/08/10 presented as soon as allowed -> data_ok every 2nd cycle with the three correct words in order.
